// File: rtl/ps2_kb_receiver.sv
// PS/2 keyboard receiver: filters the PS/2 clock, deserializes 11-bit frames and
// tracks the held key's make code with 0xE0/0xF0 prefix decoding.
// state  | meaning
// IDLE   | waiting for a start bit
// DATA   | shifting in d0..d7
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, then decoding the byte
module ps2_kb_receiver #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] kb_code,
  output logic       kb_ext,
  output logic [7:0] kb_byte,
  output logic       kb_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      ck_s_q, ck_s_d;
  logic [1:0]      dt_s_q, dt_s_d;
  logic            filt_q, filt_d;
  logic [FW-1:0]   flt_cnt_q, flt_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            par_q, par_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]      kb_code_q, kb_code_d;
  logic            kb_ext_q, kb_ext_d;
  logic [7:0]      kb_byte_q, kb_byte_d;
  logic            kb_valid_q, kb_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            ext_pend_q, ext_pend_d;
  logic            brk_pend_q, brk_pend_d;
  logic            fall;
  logic            dt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ck_s_q      <= 2'b11;
      dt_s_q      <= 2'b11;
      filt_q      <= 1'b1;
      flt_cnt_q   <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      kb_code_q   <= '0;
      kb_ext_q    <= 1'b0;
      kb_byte_q   <= '0;
      kb_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ck_s_q      <= ck_s_d;
      dt_s_q      <= dt_s_d;
      filt_q      <= filt_d;
      flt_cnt_q   <= flt_cnt_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      kb_code_q   <= kb_code_d;
      kb_ext_q    <= kb_ext_d;
      kb_byte_q   <= kb_byte_d;
      kb_valid_q  <= kb_valid_d;
      frame_err_q <= frame_err_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
    end
  end

  // Synchronizers and clock filter: the filtered level flips only after the
  // synchronized pin has disagreed with it for FILTER_LEN consecutive cycles.
  always_comb begin
    ck_s_d    = {ck_s_q[0], ps2_clk};
    dt_s_d    = {dt_s_q[0], ps2_data};
    filt_d    = filt_q;
    flt_cnt_d = '0;
    if (ck_s_q[1] != filt_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = ck_s_q[1];
      else                                  flt_cnt_d = flt_cnt_q + 1'b1;
    end
  end

  assign fall = filt_q & ~filt_d;
  assign dt   = dt_s_q[1];

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    par_d       = par_q;
    to_cnt_d    = to_cnt_q;
    kb_code_d   = kb_code_q;
    kb_ext_d    = kb_ext_q;
    kb_byte_d   = kb_byte_q;
    kb_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;

    if (state_q == S_IDLE) begin
      to_cnt_d = '0;
      if (fall) begin
        if (!dt) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end else begin
          frame_err_d = 1'b1;
        end
      end
    end else begin
      to_cnt_d = fall ? '0 : to_cnt_q + 1'b1;
      if (fall) begin
        case (state_q)
          S_DATA: begin
            shift_d   = {dt, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_d = S_PARITY;
          end
          S_PARITY: begin
            par_d   = dt;
            state_d = S_STOP;
          end
          default: begin
            state_d = S_IDLE;
            if (dt && (^{shift_q, par_q})) begin
              kb_byte_d  = shift_q;
              kb_valid_d = 1'b1;
              if (shift_q == 8'hE0) begin
                ext_pend_d = 1'b1;
              end else if (shift_q == 8'hF0) begin
                brk_pend_d = 1'b1;
              end else begin
                if (!brk_pend_q) begin
                  kb_code_d = shift_q;
                  kb_ext_d  = ext_pend_q;
                end else if (shift_q == kb_code_q && ext_pend_q == kb_ext_q) begin
                  kb_code_d = 8'h00;
                  kb_ext_d  = 1'b0;
                end
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
              end
            end else begin
              frame_err_d = 1'b1;
            end
          end
        endcase
      end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
        // Counter equals TIMEOUT in the cycle frame_err is raised; IDLE clears it after.
        state_d     = S_IDLE;
        shift_d     = '0;
        bit_cnt_d   = '0;
        ext_pend_d  = 1'b0;
        brk_pend_d  = 1'b0;
        frame_err_d = 1'b1;
      end
    end
  end

  assign kb_code   = kb_code_q;
  assign kb_ext    = kb_ext_q;
  assign kb_byte   = kb_byte_q;
  assign kb_valid  = kb_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_kb_receiver.sv
// Scoreboard bench for ps2_kb_receiver: random and directed PS/2 frames, expected
// events queued from a key-tracking model, popped by a monitor on each output pulse.
module tb_ps2_kb_receiver;

  localparam int TIMEOUT = 10000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] kb_code;
  logic       kb_ext;
  logic [7:0] kb_byte;
  logic       kb_valid;
  logic       frame_err;

  ps2_kb_receiver #(.FILTER_LEN(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .kb_code(kb_code), .kb_ext(kb_ext), .kb_byte(kb_byte),
    .kb_valid(kb_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic [7:0] b;
    logic [7:0] code;
    logic       ext;
  } ev_t;

  ev_t  exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   pulse_cnt = 0;

  // Reference: which key is held, and which prefixes are waiting for a final byte.
  logic [7:0] m_code = 8'h00;
  logic       m_ext = 1'b0;
  logic       m_ep = 1'b0;
  logic       m_bp = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (kb_valid || frame_err)) begin
      ev_t e;
      pulse_cnt++;
      chk("valid_err_overlap", int'(kb_valid & frame_err), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind_err", int'(frame_err), int'(e.err));
        if (!e.err) chk("kb_byte", kb_byte, e.b);
        chk("kb_code", kb_code, e.code);
        chk("kb_ext", int'(kb_ext), int'(e.ext));
      end
    end
  end

  task automatic model_frame(input logic [7:0] d, input bit ok);
    ev_t e;
    e.err = !ok;
    e.b   = d;
    if (ok) begin
      if (d == 8'hE0) m_ep = 1'b1;
      else if (d == 8'hF0) m_bp = 1'b1;
      else begin
        if (!m_bp) begin
          m_code = d;
          m_ext  = m_ep;
        end else if (d == m_code && m_ep == m_ext) begin
          m_code = 8'h00;
          m_ext  = 1'b0;
        end
        m_ep = 1'b0;
        m_bp = 1'b0;
      end
    end
    e.code = m_code;
    e.ext  = m_ext;
    exp_q.push_back(e);
  endtask

  function automatic logic [10:0] mk_bits(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic par;
    par = (~^d) ^ bad_par;
    return {~bad_stop, par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n, input int h);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (h) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (h) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("events_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input int h);
    model_frame(d, !(bad_par || bad_stop));
    send_bits(mk_bits(d, bad_par, bad_stop), 11, h);
    repeat (h) @(negedge clk);
    wait_drain(60);
  endtask

  initial begin
    logic [10:0] bits;
    int          pc;
    logic [7:0]  d;

    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_kb_code", kb_code, 0);
    chk("rst_kb_ext", int'(kb_ext), 0);
    chk("rst_kb_byte", kb_byte, 0);
    chk("rst_kb_valid", int'(kb_valid), 0);
    chk("rst_frame_err", int'(frame_err), 0);

    // Make 0x23 with a slow bit period
    frame(8'h23, 0, 0, 200);
    // Make, break, make-code
    frame(8'hF0, 0, 0, 20);
    frame(8'h23, 0, 0, 20);
    // Extended key, non-extended break that must not release it, extended break
    frame(8'hE0, 0, 0, 20);
    frame(8'h75, 0, 0, 20);
    frame(8'hF0, 0, 0, 20);
    frame(8'h75, 0, 0, 20);
    frame(8'hE0, 0, 0, 20);
    frame(8'hF0, 0, 0, 20);
    frame(8'h75, 0, 0, 20);
    // Parity and stop errors leave the held key alone
    frame(8'h23, 0, 0, 20);
    frame(8'h23, 1, 0, 20);
    frame(8'h1C, 0, 1, 20);

    // Timeout after 5 bits; the pending 0xE0 must be discarded with the frame
    frame(8'hE0, 0, 0, 20);
    exp_q.push_back('{err: 1'b1, b: 8'h00, code: m_code, ext: m_ext});
    m_ep = 1'b0;
    m_bp = 1'b0;
    send_bits(mk_bits(8'h1C, 0, 0), 5, 20);
    wait_drain(TIMEOUT + 100);
    repeat (10) @(negedge clk);
    frame(8'h1C, 0, 0, 20);

    // Short glitches on an idle bus
    pc = pulse_cnt;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (20) @(negedge clk);
    end
    chk("glitch_no_pulse", pulse_cnt, pc);

    // Reset in the middle of bit 4
    frame(8'h23, 0, 0, 20);
    bits = mk_bits(8'h2B, 0, 0);
    send_bits(bits, 3, 20);
    @(negedge clk);
    ps2_data = bits[3];
    repeat (20) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_kb_code", kb_code, 0);
    chk("midrst_kb_ext", int'(kb_ext), 0);
    chk("midrst_kb_byte", kb_byte, 0);
    chk("midrst_kb_valid", int'(kb_valid), 0);
    chk("midrst_frame_err", int'(frame_err), 0);
    exp_q.delete();
    m_code = 8'h00; m_ext = 1'b0; m_ep = 1'b0; m_bp = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    frame(8'h23, 0, 0, 20);

    // Randomized traffic biased toward prefixes and the currently held code
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       d = 8'hE0;
        1:       d = 8'hF0;
        2:       d = m_code;
        default: d = 8'($urandom_range(1, 255));
      endcase
      frame(d, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(12, 30));
    end

    wait_drain(100);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
